// File: rtl/apb_uart_pkg.sv
// apb_uart_pkg: register map, STATUS bit positions, parity modes and FSM states
// shared by the UART top level and its baud generator.
package apb_uart_pkg;

    localparam int BAUD_W = 13;

    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_CTRL3  = 5'h14;

    localparam int STAT_TXRDY   = 0;
    localparam int STAT_RXRDY   = 1;
    localparam int STAT_PARERR  = 2;
    localparam int STAT_OVERFLW = 3;
    localparam int STAT_FRMERR  = 4;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

    // Parity bit that makes data plus parity even (or odd when odd=1); bit7 ignored in 7-bit mode.
    function automatic logic calc_parity(input logic [7:0] data, input logic bit8, input logic odd);
        logic [7:0] masked;
        masked = bit8 ? data : {1'b0, data[6:0]};
        return (^masked) ^ odd;
    endfunction

endpackage

// File: rtl/apb_uart_baud_gen.sv
// apb_uart_baud_gen: 16x-oversampling tick, one tick every baud+1 PCLKs.
// With APB_UART_BAUD_FRCTN_EN, i_frctn of every 8 tick periods are one PCLK longer.
module apb_uart_baud_gen
    import apb_uart_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [BAUD_W-1:0] i_baud,
`ifdef APB_UART_BAUD_FRCTN_EN
    input  logic [2:0]        i_frctn,
`endif
    output logic              o_tick
);

    logic [BAUD_W:0] r_cnt;
    logic [BAUD_W:0] w_limit;
    logic            r_tick;

`ifdef APB_UART_BAUD_FRCTN_EN
    logic [2:0] r_grp;

    assign w_limit = {1'b0, i_baud} + {{BAUD_W{1'b0}}, (r_grp < i_frctn)};

    // Position within the group of 8 ticks selects which periods get stretched.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grp <= 3'd0;
        end else if (r_cnt >= w_limit) begin
            r_grp <= r_grp + 3'd1;
        end
    end
`else
    assign w_limit = {1'b0, i_baud};
`endif

    // Divisor counter; >= keeps it bounded when the divisor is lowered mid-count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt >= w_limit) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + {{BAUD_W{1'b0}}, 1'b1};
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/apb_uart.sv
// apb_uart: APB slave UART, 16x oversampling, 7/8 data bits, optional parity, one stop bit.
// Define APB_UART_BAUD_FRCTN_EN to add the fractional-divisor register CTRL3 at 0x14.
module apb_uart
    import apb_uart_pkg::*;
#(
    parameter bit          FIXEDMODE  = 1'b0,
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter bit          PRG_BIT8   = 1'b1,
    parameter logic [1:0]  PRG_PARITY = 2'd0
)(
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [4:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    output logic       TXRDY,
    output logic       RXRDY,
    output logic       PARITY_ERR,
    output logic       FRAMING_ERR,
    output logic       OVERFLOW,
    input  logic       RX,
    output logic       TX
);

    logic w_wr, w_rd_acc, w_wr_txdata, w_rd_rxdata, w_rd_status;
    assign w_wr        = PSEL & PENABLE & PWRITE;
    assign w_rd_acc    = PSEL & PENABLE & ~PWRITE;
    assign w_wr_txdata = w_wr & (PADDR == ADDR_TXDATA);
    assign w_rd_rxdata = w_rd_acc & (PADDR == ADDR_RXDATA);
    assign w_rd_status = w_rd_acc & (PADDR == ADDR_STATUS);

    logic [7:0] r_ctrl1, r_ctrl2;
`ifdef APB_UART_BAUD_FRCTN_EN
    logic [2:0] r_ctrl3;
`endif

    // Control registers; writes are ignored in fixed mode.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_ctrl1 <= 8'h00;
            r_ctrl2 <= 8'h00;
`ifdef APB_UART_BAUD_FRCTN_EN
            r_ctrl3 <= 3'd0;
`endif
        end else if (w_wr && !FIXEDMODE) begin
            if (PADDR == ADDR_CTRL1) r_ctrl1 <= PWDATA;
            if (PADDR == ADDR_CTRL2) r_ctrl2 <= PWDATA;
`ifdef APB_UART_BAUD_FRCTN_EN
            if (PADDR == ADDR_CTRL3) r_ctrl3 <= PWDATA[2:0];
`endif
        end
    end

    logic [12:0] w_baud;
    logic        w_bit8, w_par_en, w_odd, w_tick;
    logic [2:0]  w_last_bit;
    assign w_baud     = FIXEDMODE ? BAUD_VALUE : {r_ctrl2[7:3], r_ctrl1};
    assign w_bit8     = FIXEDMODE ? PRG_BIT8 : r_ctrl2[0];
    assign w_par_en   = FIXEDMODE ? (PRG_PARITY != PAR_NONE) : r_ctrl2[1];
    assign w_odd      = FIXEDMODE ? (PRG_PARITY == PAR_ODD) : r_ctrl2[2];
    assign w_last_bit = w_bit8 ? 3'd7 : 3'd6;

    apb_uart_baud_gen u_baud (
        .i_clk   (PCLK),
        .i_rst   (PRESET),
        .i_baud  (w_baud),
`ifdef APB_UART_BAUD_FRCTN_EN
        .i_frctn (r_ctrl3),
`endif
        .o_tick  (w_tick)
    );

    // ---------------- transmitter ----------------
    uart_state_e r_tx_state, w_tx_state_nx;
    logic [3:0]  r_tx_cnt, w_tx_cnt_nx;
    logic [2:0]  r_tx_bit, w_tx_bit_nx;
    logic [7:0]  r_tx_shift, w_tx_shift_nx, r_tx_hold;
    logic        r_tx_par, w_tx_par_nx, r_tx_loaded, w_tx_loaded_nx;
    logic        r_tx, w_tx_nx, w_tx_take, w_tx_bit_end, r_txrdy;
    assign w_tx_bit_end = w_tick & (r_tx_cnt == 4'hF);

    // TX next state: r_tx_loaded marks a frame waiting in IDLE for its first tick.
    always_comb begin
        w_tx_state_nx  = r_tx_state;
        w_tx_cnt_nx    = r_tx_cnt + {3'b000, w_tick};
        w_tx_bit_nx    = r_tx_bit;
        w_tx_shift_nx  = r_tx_shift;
        w_tx_par_nx    = r_tx_par;
        w_tx_loaded_nx = r_tx_loaded;
        w_tx_nx        = r_tx;
        w_tx_take      = 1'b0;
        case (r_tx_state)
            IDLE: begin
                w_tx_cnt_nx = 4'd0;
                w_tx_nx     = 1'b1;
                if (!r_tx_loaded && !r_txrdy) begin
                    w_tx_take      = 1'b1;
                    w_tx_loaded_nx = 1'b1;
                    w_tx_shift_nx  = r_tx_hold;
                    w_tx_par_nx    = calc_parity(r_tx_hold, w_bit8, w_odd);
                end else if (r_tx_loaded && w_tick) begin
                    w_tx_state_nx = START;
                    w_tx_nx       = 1'b0;
                end else begin
                    w_tx_take = 1'b0;
                end
            end
            START: begin
                if (w_tx_bit_end) begin
                    w_tx_state_nx = DATA;
                    w_tx_bit_nx   = 3'd0;
                    w_tx_nx       = r_tx_shift[0];
                end else begin
                    w_tx_state_nx = START;
                end
            end
            DATA: begin
                if (w_tx_bit_end) begin
                    w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_nx   = r_tx_bit + 3'd1;
                    if (r_tx_bit != w_last_bit) begin
                        w_tx_nx = r_tx_shift[1];
                    end else if (w_par_en) begin
                        w_tx_state_nx = PARITY;
                        w_tx_nx       = r_tx_par;
                    end else begin
                        w_tx_state_nx = STOP;
                        w_tx_nx       = 1'b1;
                    end
                end else begin
                    w_tx_state_nx = DATA;
                end
            end
            PARITY: begin
                if (w_tx_bit_end) begin
                    w_tx_state_nx = STOP;
                    w_tx_nx       = 1'b1;
                end else begin
                    w_tx_state_nx = PARITY;
                end
            end
            STOP: begin
                // A waiting holding register starts the next frame with no idle gap.
                if (w_tx_bit_end && !r_txrdy) begin
                    w_tx_take     = 1'b1;
                    w_tx_shift_nx = r_tx_hold;
                    w_tx_par_nx   = calc_parity(r_tx_hold, w_bit8, w_odd);
                    w_tx_state_nx = START;
                    w_tx_nx       = 1'b0;
                end else if (w_tx_bit_end) begin
                    w_tx_state_nx  = IDLE;
                    w_tx_loaded_nx = 1'b0;
                    w_tx_nx        = 1'b1;
                end else begin
                    w_tx_state_nx = STOP;
                end
            end
            default: begin
                w_tx_state_nx  = IDLE;
                w_tx_loaded_nx = 1'b0;
                w_tx_nx        = 1'b1;
            end
        endcase
    end

    // TX state register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_tx_state  <= IDLE;
            r_tx_cnt    <= 4'd0;
            r_tx_bit    <= 3'd0;
            r_tx_shift  <= 8'h00;
            r_tx_par    <= 1'b0;
            r_tx_loaded <= 1'b0;
            r_tx        <= 1'b1;
        end else begin
            r_tx_state  <= w_tx_state_nx;
            r_tx_cnt    <= w_tx_cnt_nx;
            r_tx_bit    <= w_tx_bit_nx;
            r_tx_shift  <= w_tx_shift_nx;
            r_tx_par    <= w_tx_par_nx;
            r_tx_loaded <= w_tx_loaded_nx;
            r_tx        <= w_tx_nx;
        end
    end

    // Holding register: a write in the transfer cycle wins so no byte is lost.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_tx_hold <= 8'h00;
            r_txrdy   <= 1'b1;
        end else if (w_wr_txdata) begin
            r_tx_hold <= PWDATA;
            r_txrdy   <= 1'b0;
        end else if (w_tx_take) begin
            r_txrdy   <= 1'b1;
        end
    end

    // ---------------- receiver ----------------
    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    uart_state_e r_rx_state, w_rx_state_nx;
    logic [3:0]  r_rx_cnt, w_rx_cnt_nx;
    logic [2:0]  r_rx_bit, w_rx_bit_nx;
    logic [7:0]  r_rx_shift, w_rx_shift_nx, r_rxdata;
    logic        w_rx_done, w_rx_perr, w_rx_ferr, w_rx_bit_end;
    logic        r_rxrdy, r_perr, r_ferr, r_ovf;
    assign w_rx_bit_end = w_tick & (r_rx_cnt == 4'hF);

    // RX next state: start is re-checked after 8 ticks, later bits every 16 ticks.
    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt + {3'b000, w_tick};
        w_rx_bit_nx   = r_rx_bit;
        w_rx_shift_nx = r_rx_shift;
        w_rx_done     = 1'b0;
        w_rx_perr     = 1'b0;
        w_rx_ferr     = 1'b0;
        case (r_rx_state)
            IDLE: begin
                w_rx_cnt_nx = 4'd0;
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_state_nx = START;
                end else begin
                    w_rx_state_nx = IDLE;
                end
            end
            START: begin
                if (w_tick && r_rx_cnt == 4'd7) begin
                    w_rx_cnt_nx   = 4'd0;
                    w_rx_bit_nx   = 3'd0;
                    w_rx_shift_nx = 8'h00;
                    w_rx_state_nx = r_rx_sync ? IDLE : DATA;
                end else begin
                    w_rx_state_nx = START;
                end
            end
            DATA: begin
                if (w_rx_bit_end) begin
                    w_rx_shift_nx[r_rx_bit] = r_rx_sync;
                    w_rx_bit_nx             = r_rx_bit + 3'd1;
                    if (r_rx_bit != w_last_bit) begin
                        w_rx_state_nx = DATA;
                    end else begin
                        w_rx_state_nx = w_par_en ? PARITY : STOP;
                    end
                end else begin
                    w_rx_state_nx = DATA;
                end
            end
            PARITY: begin
                if (w_rx_bit_end) begin
                    w_rx_perr     = calc_parity(r_rx_shift, w_bit8, w_odd) ^ r_rx_sync;
                    w_rx_state_nx = STOP;
                end else begin
                    w_rx_state_nx = PARITY;
                end
            end
            STOP: begin
                if (w_rx_bit_end) begin
                    w_rx_done     = r_rx_sync;
                    w_rx_ferr     = ~r_rx_sync;
                    w_rx_state_nx = IDLE;
                end else begin
                    w_rx_state_nx = STOP;
                end
            end
            default: begin
                w_rx_state_nx = IDLE;
            end
        endcase
    end

    // RX synchronizer and state register; r_rx_prev also blocks rearming while RX stays low.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= IDLE;
            r_rx_cnt   <= 4'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_meta  <= RX;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_bit   <= w_rx_bit_nx;
            r_rx_shift <= w_rx_shift_nx;
        end
    end

    // RX data and sticky flags; a set in the same cycle as a clearing read wins.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_rxdata <= 8'h00;
            r_rxrdy  <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_rx_done && !r_rxrdy) r_rxdata <= r_rx_shift;
            if (w_rx_done)             r_rxrdy  <= 1'b1;
            else if (w_rd_rxdata)      r_rxrdy  <= 1'b0;
            if (w_rx_done && r_rxrdy)  r_ovf    <= 1'b1;
            else if (w_rd_status)      r_ovf    <= 1'b0;
            if (w_rx_perr)             r_perr   <= 1'b1;
            else if (w_rd_status)      r_perr   <= 1'b0;
            if (w_rx_ferr)             r_ferr   <= 1'b1;
            else if (w_rd_status)      r_ferr   <= 1'b0;
        end
    end

    // ---------------- APB read ----------------
    logic [7:0] w_status;

    // STATUS register assembly.
    always_comb begin
        w_status               = 8'h00;
        w_status[STAT_TXRDY]   = r_txrdy;
        w_status[STAT_RXRDY]   = r_rxrdy;
        w_status[STAT_PARERR]  = r_perr;
        w_status[STAT_OVERFLW] = r_ovf;
        w_status[STAT_FRMERR]  = r_ferr;
    end

    // Read mux; data is driven only during a read transfer.
    always_comb begin
        PRDATA = 8'h00;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                ADDR_RXDATA: PRDATA = r_rxdata;
                ADDR_CTRL1:  PRDATA = FIXEDMODE ? 8'h00 : r_ctrl1;
                ADDR_CTRL2:  PRDATA = FIXEDMODE ? 8'h00 : r_ctrl2;
                ADDR_STATUS: PRDATA = w_status;
`ifdef APB_UART_BAUD_FRCTN_EN
                ADDR_CTRL3:  PRDATA = {5'b00000, r_ctrl3};
`endif
                default:     PRDATA = 8'h00;
            endcase
        end else begin
            PRDATA = 8'h00;
        end
    end

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign TXRDY       = r_txrdy;
    assign RXRDY       = r_rxrdy;
    assign PARITY_ERR  = r_perr;
    assign FRAMING_ERR = r_ferr;
    assign OVERFLOW    = r_ovf;
    assign TX          = r_tx;

endmodule

// File: tb/tb_apb_uart.sv
// tb_apb_uart: two apb_uart instances, A's TX looped into B's RX, with directed
// checks of reset state, loopback, parity, overflow, framing and 7-bit mode.
module tb_apb_uart;

    logic       PCLK = 1'b0;
    logic       PRESET, psel_a, psel_b, PENABLE, PWRITE, force_low;
    logic [4:0] PADDR;
    logic [7:0] PWDATA, prdata_a, prdata_b, rd;
    logic       pready_a, pslverr_a, txrdy_a, rxrdy_a, perr_a, ferr_a, ovf_a, tx_a;
    logic       pready_b, pslverr_b, txrdy_b, rxrdy_b, perr_b, ferr_b, ovf_b, tx_b;
    logic       rx_b;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc;

    assign rx_b = force_low ? 1'b0 : tx_a;

    always #5 PCLK = ~PCLK;

    apb_uart u_dut_a (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_a), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a),
        .TXRDY(txrdy_a), .RXRDY(rxrdy_a), .PARITY_ERR(perr_a), .FRAMING_ERR(ferr_a),
        .OVERFLOW(ovf_a), .RX(1'b1), .TX(tx_a)
    );

    apb_uart u_dut_b (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_b), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b),
        .TXRDY(txrdy_b), .RXRDY(rxrdy_b), .PARITY_ERR(perr_b), .FRAMING_ERR(ferr_b),
        .OVERFLOW(ovf_b), .RX(rx_b), .TX(tx_b)
    );

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic which, input logic [4:0] addr, input logic [7:0] data);
        @(negedge PCLK);
        psel_a = ~which; psel_b = which; PADDR = addr; PWDATA = data; PWRITE = 1'b1; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic which, input logic [4:0] addr, output logic [7:0] data);
        @(negedge PCLK);
        psel_a = ~which; psel_b = which; PADDR = addr; PWRITE = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 data = which ? prdata_b : prdata_a;
        @(negedge PCLK);
        psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
    endtask

    // which: 0 = B.RXRDY, 1 = B.OVERFLOW, other = B.FRAMING_ERR
    task automatic wait_flag(input string tag, input int which, input int limit, output int n);
        logic f;
        n = 0;
        f = 1'b0;
        while (n < limit) begin
            case (which)
                0:       f = rxrdy_b;
                1:       f = ovf_b;
                default: f = ferr_b;
            endcase
            if (f === 1'b1) break;
            @(negedge PCLK);
            n++;
        end
        check_eq(tag, {7'd0, f}, 8'h01);
    endtask

    task automatic set_ctrl2(input logic [7:0] ca, input logic [7:0] cb);
        apb_write(1'b0, 5'h0C, ca);
        apb_write(1'b1, 5'h0C, cb);
        repeat (4) @(negedge PCLK);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] zaddr [6];
        zaddr[0] = 5'h00; zaddr[1] = 5'h04; zaddr[2] = 5'h08;
        zaddr[3] = 5'h0C; zaddr[4] = 5'h14; zaddr[5] = 5'h18;
        PRESET = 1'b1; psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 5'h00; PWDATA = 8'h00; force_low = 1'b0;
        repeat (4) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);

        // reset state
        check_eq("reset_tx", {7'd0, tx_a}, 8'h01);
        check_eq("reset_flags", {3'd0, txrdy_b, rxrdy_b, perr_b, ferr_b, ovf_b}, 8'h10);
        apb_read(1'b1, 5'h10, rd);
        check_eq("reset_status", rd, 8'h01);
        for (int i = 0; i < 6; i++) begin
            apb_read(1'b1, zaddr[i], rd);
            check_eq("reset_read_zero", rd, 8'h00);
        end

        // baud=1, 8N1 on both
        apb_write(1'b0, 5'h08, 8'h01);
        apb_write(1'b1, 5'h08, 8'h01);
        set_ctrl2(8'h01, 8'h01);
        apb_read(1'b1, 5'h08, rd);
        check_eq("ctrl1_readback", rd, 8'h01);
        apb_read(1'b1, 5'h0C, rd);
        check_eq("ctrl2_readback", rd, 8'h01);

        // loopback 0x55
        apb_write(1'b0, 5'h00, 8'h55);
        check_eq("txrdy_low_after_write", {7'd0, txrdy_a}, 8'h00);
        @(negedge PCLK);
        check_eq("txrdy_back_high", {7'd0, txrdy_a}, 8'h01);
        wait_flag("loop_rxrdy_timeout", 0, 1000, cyc);
        check_eq("loop_latency_in_range", {7'd0, (cyc >= 290 && cyc <= 340)}, 8'h01);
        apb_read(1'b1, 5'h10, rd);
        check_eq("loop_status", rd, 8'h03);
        apb_read(1'b1, 5'h04, rd);
        check_eq("loop_rxdata", rd, 8'h55);
        check_eq("loop_rxrdy_cleared", {7'd0, rxrdy_b}, 8'h00);
        repeat (64) @(negedge PCLK);
        check_eq("tx_idle_high", {7'd0, tx_a}, 8'h01);

        // parity mismatch: sender even, receiver odd
        set_ctrl2(8'h03, 8'h07);
        apb_write(1'b0, 5'h00, 8'hA3);
        wait_flag("par_rxrdy_timeout", 0, 1000, cyc);
        check_eq("par_err_set", {7'd0, perr_b}, 8'h01);
        apb_read(1'b1, 5'h10, rd);
        check_eq("par_status", rd, 8'h07);
        check_eq("par_err_cleared", {7'd0, perr_b}, 8'h00);
        apb_read(1'b1, 5'h04, rd);
        check_eq("par_rxdata", rd, 8'hA3);
        repeat (64) @(negedge PCLK);

        // parity match: both even
        set_ctrl2(8'h03, 8'h03);
        apb_write(1'b0, 5'h00, 8'hA3);
        wait_flag("parok_rxrdy_timeout", 0, 1000, cyc);
        check_eq("parok_no_err", {7'd0, perr_b}, 8'h00);
        apb_read(1'b1, 5'h04, rd);
        check_eq("parok_rxdata", rd, 8'hA3);
        repeat (64) @(negedge PCLK);

        // overflow: back-to-back 0x11, 0x22 without reading
        set_ctrl2(8'h01, 8'h01);
        apb_write(1'b0, 5'h00, 8'h11);
        apb_write(1'b0, 5'h00, 8'h22);
        check_eq("ovf_hold_full", {7'd0, txrdy_a}, 8'h00);
        wait_flag("ovf_timeout", 1, 1500, cyc);
        check_eq("ovf_latency_in_range", {7'd0, (cyc >= 600 && cyc <= 680)}, 8'h01);
        apb_read(1'b1, 5'h04, rd);
        check_eq("ovf_rxdata_kept", rd, 8'h11);
        apb_read(1'b1, 5'h10, rd);
        check_eq("ovf_status", rd, 8'h09);
        check_eq("ovf_cleared", {7'd0, ovf_b}, 8'h00);
        repeat (64) @(negedge PCLK);

        // framing: RX held low
        force_low = 1'b1;
        wait_flag("frm_timeout", 2, 1000, cyc);
        check_eq("frm_latency_in_range", {7'd0, (cyc >= 290 && cyc <= 340)}, 8'h01);
        check_eq("frm_no_rxrdy", {7'd0, rxrdy_b}, 8'h00);
        repeat (700) @(negedge PCLK);
        apb_read(1'b1, 5'h10, rd);
        check_eq("frm_status", rd, 8'h11);
        repeat (400) @(negedge PCLK);
        check_eq("frm_no_repeat", {7'd0, ferr_b}, 8'h00);
        force_low = 1'b0;
        repeat (64) @(negedge PCLK);
        check_eq("frm_idle_after_release", {6'd0, rxrdy_b, ferr_b}, 8'h00);

        // 7-bit mode
        set_ctrl2(8'h00, 8'h00);
        apb_write(1'b0, 5'h00, 8'hFF);
        wait_flag("bit7_rxrdy_timeout", 0, 1000, cyc);
        apb_read(1'b1, 5'h04, rd);
        check_eq("bit7_rxdata", rd, 8'h7F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
